// File: rtl/data_memory_ctrl.sv
// Byte-addressed data memory with an init sweep, load/store request handshake and one-cycle response.
// Optional DMEM_MISALIGN_TRAP_EN: accesses not aligned to their size are rejected as errors.
`default_nettype none

module dmem_lane #(
  parameter int LANE = 0,
  parameter int AW   = 8
) (
  input  logic [AW-1:0] i_base,
  input  logic [3:0]    i_nbytes,
  output logic [AW-1:0] o_addr,
  output logic          o_en
);
  assign o_addr = i_base + AW'(LANE);
  assign o_en   = 4'(LANE) < i_nbytes;
endmodule

module data_memory_ctrl #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_read,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              rsp_valid,
  output logic [63:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
);
  localparam int AW        = $clog2(DEPTH);
  localparam int NUM_LANES = 8;

  typedef enum logic [1:0] {INIT, IDLE, RESP} state_t;

  state_t          r_state;
  logic [AW-1:0]   r_cnt;
  logic [7:0]      r_mem [DEPTH];
  logic            r_ready;
  logic            r_rsp_valid;
  logic [63:0]     r_rdata;
  logic            r_err;
  logic            r_init_done;

  logic [3:0]      w_nbytes;
  logic [ADDR_W:0] w_last;
  logic            w_oob;
  logic            w_rw_bad;
  logic            w_misalign;
  logic            w_err;
  logic            w_store;
  logic            w_sign;
  logic            w_fill;

  logic [NUM_LANES-1:0][AW-1:0] w_lane_addr;
  logic [NUM_LANES-1:0]         w_lane_en;
  logic [NUM_LANES-1:0][7:0]    w_rbytes;
  logic [NUM_LANES-1:0][7:0]    w_ext;

  assign w_nbytes = 4'd1 << req_size;
  // Range check at ADDR_W+1 bits so addresses near the top of the space cannot wrap to look legal.
  assign w_last   = {1'b0, req_addr} + (ADDR_W+1)'(w_nbytes - 4'd1);
  assign w_oob    = w_last >= (ADDR_W+1)'(DEPTH);
  assign w_rw_bad = req_read == req_write;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_misalign = |(req_addr[2:0] & 3'(w_nbytes - 4'd1));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_err   = w_oob | w_rw_bad | w_misalign;
  assign w_store = (r_state == IDLE) & req_valid & req_write & ~w_err;

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    dmem_lane #(.LANE(gi), .AW(AW)) u_lane (
      .i_base   (req_addr[AW-1:0]),
      .i_nbytes (w_nbytes),
      .o_addr   (w_lane_addr[gi]),
      .o_en     (w_lane_en[gi])
    );
    assign w_rbytes[gi] = w_lane_en[gi] ? r_mem[w_lane_addr[gi]] : 8'h00;
  end

  always_comb begin
    w_sign = 1'b0;
    case (req_size)
      2'd0:    w_sign = w_rbytes[0][7];
      2'd1:    w_sign = w_rbytes[1][7];
      2'd2:    w_sign = w_rbytes[3][7];
      default: w_sign = 1'b0;
    endcase
    w_fill = ~req_unsigned & w_sign;
    w_ext  = w_rbytes;
    for (int i = 0; i < NUM_LANES; i++)
      if (!w_lane_en[i]) w_ext[i] = {8{w_fill}};
  end

  // Storage has no reset; the INIT sweep gives it a known image after every reset.
  always_ff @(posedge clk) begin
    if (r_state == INIT)
      r_mem[r_cnt] <= 8'(r_cnt);
    else if (w_store)
      for (int i = 0; i < NUM_LANES; i++)
        if (w_lane_en[i]) r_mem[w_lane_addr[i]] <= req_wdata[8*i +: 8];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= INIT;
      r_cnt       <= '0;
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        INIT: begin
          r_cnt <= r_cnt + AW'(1);
          if (r_cnt == AW'(DEPTH - 1)) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
          end
        end
        IDLE: begin
          r_init_done <= 1'b1;
          if (req_valid) begin
            r_state     <= RESP;
            r_ready     <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_err       <= w_err;
            r_rdata     <= (w_err || req_write) ? 64'd0 : w_ext;
          end
        end
        RESP: begin
          r_state     <= IDLE;
          r_ready     <= 1'b1;
          r_rsp_valid <= 1'b0;
        end
        default: r_state <= INIT;
      endcase
    end
  end

  assign req_ready = r_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign init_done = r_init_done;

endmodule

`default_nettype wire

// File: doc/data_memory_ctrl.md
DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

Interface
REQ-001 Parameter DEPTH, default 256, memory size in bytes; power of two, minimum 8.
REQ-002 Parameter ADDR_W, default 64, request address width in bits.
REQ-003 Port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port req_valid  input  1  request present.
REQ-006 Port req_ready  output  1  block can accept a request this cycle.
REQ-007 Port req_write  input  1  store request.
REQ-008 Port req_read  input  1  load request.
REQ-009 Port req_size  input  2  access size: 0 = byte, 1 = half, 2 = word, 3 = double.
REQ-010 Port req_unsigned  input  1  loads zero-extend when 1 and sign-extend when 0.
REQ-011 Port req_addr  input  ADDR_W  byte address of the lowest byte.
REQ-012 Port req_wdata  input  64  store data; low 8·2^size bits used.
REQ-013 Port rsp_valid  output  1  one-cycle response strobe.
REQ-014 Port rsp_rdata  output  64  extended load data.
REQ-015 Port rsp_err  output  1  request rejected; no memory update.
REQ-016 Port init_done  output  1  initialisation sweep complete.

Function
REQ-017 Storage is DEPTH bytes, little-endian: byte i of the access maps to address req_addr+i.
REQ-018 FSM states: INIT, IDLE, RESP.
REQ-019 INIT: an internal counter writes mem[k] = k[7:0], one byte per cycle, for k = 0..DEPTH-1; on the last byte the FSM moves to IDLE and init_done rises in the next cycle; req_ready = 0.
REQ-020 IDLE: req_ready = 1; a handshake occurs when req_valid=1 at a rising edge; the FSM then moves to RESP.
REQ-021 RESP: rsp_valid = 1 for exactly one cycle with rsp_rdata and rsp_err registered; req_ready = 0; the next state is IDLE. Sustained throughput is one request per 2 cycles.
REQ-022 A store writes 2^size bytes at the accepting edge; rsp_rdata = 0 for stores.
REQ-023 A load samples 2^size bytes at the accepting edge and extends them to 64 bits according to req_unsigned; an access of size 3 ignores req_unsigned.
REQ-024 An error is raised when req_addr + 2^size - 1 >= DEPTH, evaluated without wrap-around at full ADDR_W+1 width.
REQ-025 An error is raised when req_read and req_write are both 1, or both are 0.
REQ-026 On error: no bytes are written, rsp_rdata = 0, rsp_err = 1.
REQ-027 req_valid is ignored in INIT and RESP: no queuing and no side effects.
REQ-028 Request fields are sampled only at the handshake edge; later changes have no effect on the response.

Reset
REQ-029 On reset assertion, the block immediately enters INIT with counter = 0; req_ready, rsp_valid, rsp_err and init_done are 0; rsp_rdata is 0.
REQ-030 Reset during INIT, IDLE or RESP aborts any pending response (no rsp_valid) and restarts the full sweep; stores already committed are overwritten by the sweep.

Configuration
REQ-031 Macro DMEM_MISALIGN_TRAP_EN defined: an access whose address is not a multiple of 2^size is an error per REQ-026.
REQ-032 Macro DMEM_MISALIGN_TRAP_EN undefined: misaligned accesses complete normally byte-wise; only REQ-024/REQ-025 produce errors.

Verification
REQ-033 Release reset, wait for init_done, then load double at 0x0 -> rsp_rdata = 0x0706050403020100, rsp_err = 0; init_done rises DEPTH+1 cycles after reset release.
REQ-034 Load byte at 0x80 signed -> 0xFFFFFFFFFFFFFF80; the same load unsigned -> 0x0000000000000080.
REQ-035 Store half 0x1234 at 0x10, then load double at 0x10 -> 0x1716151413121234.
REQ-036 Load word at 0x2: with DMEM_MISALIGN_TRAP_EN -> rsp_err = 1 and rdata = 0; without the macro -> 0x0000000005040302.
REQ-037 Load double at DEPTH-4 -> rsp_err = 1; store double at DEPTH-8 of 0xFF.. -> no error, and a following load double at DEPTH-8 returns all ones.
REQ-038 Assert reset while in RESP -> rsp_valid stays 0, init_done = 0, req_ready = 0 until the sweep completes; afterwards a load double at 0x10 returns 0x1716151413121110.
